// File: rtl/angle_reducer.sv
`default_nettype none
// ============================================================================
//  Module      : angle_reducer
//  Description : Reduces an unsigned integer angle modulo FULL_TURN, then
//                folds it into [0, FULL_TURN/4] with quadrant and sign flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module angle_reducer #(
    parameter int unsigned     DATA_WIDTH = 64,
    parameter longint unsigned FULL_TURN  = 360
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [1:0]            quadrant,
    output logic                  sin_neg,
    output logic                  cos_neg,
    output logic                  busy
);

    localparam int unsigned           c_CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [DATA_WIDTH-1:0] c_FULL     = DATA_WIDTH'(FULL_TURN);
    localparam logic [DATA_WIDTH+1:0] c_FULL_EXT = (DATA_WIDTH + 2)'(FULL_TURN);
    localparam logic [DATA_WIDTH-1:0] c_QUARTER  = DATA_WIDTH'(FULL_TURN / 4);
    localparam logic [DATA_WIDTH-1:0] c_HALF     = DATA_WIDTH'(FULL_TURN / 2);
    localparam logic [DATA_WIDTH-1:0] c_THREE_Q  = DATA_WIDTH'((FULL_TURN / 4) * 3);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_DIVIDE = 2'd1;
    localparam logic [1:0] c_S_FOLD   = 2'd2;
    localparam logic [1:0] c_S_DONE   = 2'd3;

    logic [1:0]            r_state;
    logic [DATA_WIDTH-1:0] r_dividend;
    logic [DATA_WIDTH:0]   r_rem;
    logic [c_CNT_W-1:0]    r_count;
    logic [DATA_WIDTH-1:0] r_angle;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic [1:0]            r_quadrant;
    logic                  r_sin_neg;
    logic                  r_cos_neg;
    logic                  r_out_valid;

    logic [DATA_WIDTH+1:0] w_shift;
    logic [DATA_WIDTH+1:0] w_rem_next;
    logic [DATA_WIDTH-1:0] w_fold_data;
    logic [1:0]            w_fold_quad;

    // Restoring step: shift in the next dividend bit, subtract the modulus if it fits.
    assign w_shift    = {r_rem, r_dividend[DATA_WIDTH-1]};
    assign w_rem_next = (w_shift >= c_FULL_EXT) ? (w_shift - c_FULL_EXT) : w_shift;

    always_comb begin
        w_fold_data = r_angle;
        w_fold_quad = 2'b00;
        if (r_angle <= c_QUARTER) begin
            w_fold_data = r_angle;
            w_fold_quad = 2'b00;
        end else if (r_angle <= c_HALF) begin
            w_fold_data = c_HALF - r_angle;
            w_fold_quad = 2'b01;
        end else if (r_angle <= c_THREE_Q) begin
            w_fold_data = r_angle - c_HALF;
            w_fold_quad = 2'b10;
        end else begin
            w_fold_data = c_FULL - r_angle;
            w_fold_quad = 2'b11;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_S_IDLE;
            r_dividend  <= '0;
            r_rem       <= '0;
            r_count     <= '0;
            r_angle     <= '0;
            r_data_out  <= '0;
            r_quadrant  <= 2'b00;
            r_sin_neg   <= 1'b0;
            r_cos_neg   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (in_valid) begin
                        if (data_in < c_FULL) begin
                            r_angle <= data_in;
                            r_state <= c_S_FOLD;
                        end else begin
                            r_dividend <= data_in;
                            r_rem      <= '0;
                            r_count    <= c_CNT_W'(DATA_WIDTH);
                            r_state    <= c_S_DIVIDE;
                        end
                    end
                end
                c_S_DIVIDE: begin
                    r_rem      <= (DATA_WIDTH + 1)'(w_rem_next);
                    r_dividend <= {r_dividend[DATA_WIDTH-2:0], 1'b0};
                    r_count    <= r_count - c_CNT_W'(1);
                    if (r_count == c_CNT_W'(1)) begin
                        r_angle <= DATA_WIDTH'(w_rem_next);
                        r_state <= c_S_FOLD;
                    end
                end
                c_S_FOLD: begin
                    r_data_out  <= w_fold_data;
                    r_quadrant  <= w_fold_quad;
                    r_sin_neg   <= w_fold_quad[1];
                    r_cos_neg   <= w_fold_quad[1] ^ w_fold_quad[0];
                    r_out_valid <= 1'b1;
                    r_state     <= c_S_DONE;
                end
                default: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_S_IDLE;
                    end
                end
            endcase
        end
    end

    assign in_ready  = (r_state == c_S_IDLE);
    assign busy      = (r_state != c_S_IDLE);
    assign out_valid = r_out_valid;
    assign data_out  = r_data_out;
    assign quadrant  = r_quadrant;
    assign sin_neg   = r_sin_neg;
    assign cos_neg   = r_cos_neg;

endmodule
`default_nettype wire

// File: tb/tb_angle_reducer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_angle_reducer
//  Description : Scoreboard bench for angle_reducer (16-bit angles, 360/turn).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_angle_reducer;

    localparam int unsigned     c_DW   = 16;
    localparam longint unsigned c_FULL = 360;

    typedef struct {
        logic [15:0] d;
        logic [1:0]  q;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] data_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] data_out;
    logic [1:0]  quadrant;
    logic        sin_neg;
    logic        cos_neg;
    logic        busy;

    exp_t sb[$];
    int   edge_cnt = 0;
    int   cmp_cnt  = 0;
    int   fail_cnt = 0;
    logic prev_ov  = 1'b0;

    angle_reducer #(.DATA_WIDTH(c_DW), .FULL_TURN(c_FULL)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .quadrant(quadrant), .sin_neg(sin_neg),
        .cos_neg(cos_neg), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        cmp_cnt++;
        if (act != exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [15:0] a, input logic [15:0] d,
                        input logic [1:0] q, input int lat);
        exp_t e;
        int   n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
        end else begin
            in_valid = 1'b1;
            data_in  = a;
            @(posedge clk); #1;
            in_valid = 1'b0;
            e.d = d; e.q = q; e.lat = lat; e.acc = edge_cnt;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk); #1; n++;
        end
        chk("drain_pending", sb.size(), 0);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor: latency on out_valid rise, payload on each transfer.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (sb.size() == 0) chk("unexpected_output", 1, 0);
                else chk("latency", edge_cnt - sb[0].acc + 1, sb[0].lat);
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                e = sb.pop_front();
                chk("data_out", data_out, e.d);
                chk("quadrant", quadrant, e.q);
                chk("sin_neg", sin_neg, (e.q == 2'b10 || e.q == 2'b11) ? 1 : 0);
                chk("cos_neg", cos_neg, (e.q == 2'b01 || e.q == 2'b10) ? 1 : 0);
            end
            prev_ov = out_valid;
        end
    end

    initial begin
        int n;
        reset = 1'b1; in_valid = 1'b0; data_in = '0; out_ready = 1'b1;
        cycles(3);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_quadrant", quadrant, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        cycles(1);

        // one angle per quadrant, then the quadrant boundaries
        send(16'd45,  16'd45, 2'b00, 2);  drain();
        send(16'd135, 16'd45, 2'b01, 2);  drain();
        send(16'd225, 16'd45, 2'b10, 2);  drain();
        send(16'd315, 16'd45, 2'b11, 2);  drain();
        send(16'd0,   16'd0,  2'b00, 2);  drain();
        send(16'd90,  16'd90, 2'b00, 2);  drain();
        send(16'd180, 16'd0,  2'b01, 2);  drain();
        send(16'd270, 16'd90, 2'b10, 2);  drain();
        send(16'd360, 16'd0,  2'b00, 18); drain();
        send(16'd760, 16'd40, 2'b00, 18); drain();
        send(16'd65535, 16'd15, 2'b00, 18); drain();

        // backpressure: 1000 -> r=280, held while out_ready low
        out_ready = 1'b0;
        send(16'd1000, 16'd80, 2'b11, 18);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("hold_valid_seen", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            data_in  = 16'd45;
            @(negedge clk);
            chk("hold_data", data_out, 80);
            chk("hold_quadrant", quadrant, 3);
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("xfer_cycle_in_ready", in_ready, 0);
        @(negedge clk);
        chk("post_xfer_in_ready", in_ready, 1);
        chk("post_xfer_valid", out_valid, 0);
        chk("post_xfer_data_kept", data_out, 80);
        chk("post_xfer_quad_kept", quadrant, 3);
        @(posedge clk); #1;
        drain();

        // reset in the middle of a divide of 5000: no output may follow
        in_valid = 1'b1;
        data_in  = 16'd5000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("div_busy", busy, 1);
        chk("div_in_ready", in_ready, 0);
        cycles(7);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_data_out", data_out, 0);
        chk("abort_quadrant", quadrant, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 1);
        @(posedge clk); #1;
        cycles(20);
        chk("abort_no_output", out_valid, 0);
        send(16'd100, 16'd80, 2'b01, 2); drain();

        // back-to-back stream with the sink always ready
        send(16'd10,  16'd10, 2'b00, 2);
        send(16'd200, 16'd20, 2'b10, 2);
        send(16'd400, 16'd40, 2'b00, 18);
        drain();
        cycles(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
